// File: rtl/bomb_pkg.sv
// -----------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the user-bomb controller and other board clients:
//   - bomb_state_t : controller state encoding (IDLE, FUSE, BLAST)
//   - board geometry (X_MATRIX, Y_MATRIX, TILE_ORDER, ROWS, COLUMNS), which
//     must match the object matrix
//   - tile index widths (COL_W for columns, ROW_W for rows)
//   - abs_diff6 : 6-bit unsigned absolute difference used by the blast compare
// -----------------------------------------------------------------------------
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } bomb_state_t;

    localparam logic [10:0] X_MATRIX   = 11'h020;
    localparam logic [10:0] Y_MATRIX   = 11'h060;
    localparam int          TILE_ORDER = 5;
    localparam int          ROWS       = 11;
    localparam int          COLUMNS    = 17;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    // Board extent in pixels, measured from the board's top-left corner.
    localparam logic [10:0] COL_SPAN = 11'(COLUMNS << TILE_ORDER);
    localparam logic [10:0] ROW_SPAN = 11'(ROWS << TILE_ORDER);

    // Operands are small tile indices, so the subtraction never wraps.
    function automatic logic [5:0] abs_diff6(input logic [5:0] a, input logic [5:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bomb_blast_if.sv
// -----------------------------------------------------------------------------
// bomb_blast_if
// Request/status bundle between the player logic (master) and the bomb
// controller (slave).
//   arm, arm_col, arm_row       : placement request (master -> slave)
//   bomb_active, blasting       : registered state decodes (slave -> master)
//   bomb_col, bomb_row          : latched bomb tile
//   fuse_left                   : remaining fuse frame ticks
//   blast_done                  : one-cycle pulse when the blast ends
// -----------------------------------------------------------------------------
interface bomb_blast_if;

    logic                          arm;
    logic [bomb_pkg::COL_W-1:0]    arm_col;
    logic [bomb_pkg::ROW_W-1:0]    arm_row;
    logic                          bomb_active;
    logic                          blasting;
    logic [bomb_pkg::COL_W-1:0]    bomb_col;
    logic [bomb_pkg::ROW_W-1:0]    bomb_row;
    logic [7:0]                    fuse_left;
    logic                          blast_done;

    modport master (
        output arm, arm_col, arm_row,
        input  bomb_active, blasting, bomb_col, bomb_row, fuse_left, blast_done
    );

    modport slave (
        input  arm, arm_col, arm_row,
        output bomb_active, blasting, bomb_col, bomb_row, fuse_left, blast_done
    );

endinterface

// File: rtl/bomb_blast_pixel_to_tile.sv
// -----------------------------------------------------------------------------
// pixel_to_tile
// Combinational pixel-to-tile mapper for the board.
//   pixel_x, pixel_y : current pixel position
//   on_board         : pixel lies inside the board rectangle
//   tc, tr           : tile column/row of the pixel (0 when off the board)
// -----------------------------------------------------------------------------
module pixel_to_tile
    import bomb_pkg::*;
(
    input  logic [10:0]      pixel_x,
    input  logic [10:0]      pixel_y,
    output logic             on_board,
    output logic [COL_W-1:0] tc,
    output logic [ROW_W-1:0] tr
);

    logic [10:0] dx;
    logic [10:0] dy;

    assign dx = pixel_x - X_MATRIX;
    assign dy = pixel_y - Y_MATRIX;

    // The lower-bound test guards against dx/dy wrapping for pixels left of
    // or above the board.
    assign on_board = (pixel_x >= X_MATRIX) && (dx < COL_SPAN) &&
                      (pixel_y >= Y_MATRIX) && (dy < ROW_SPAN);

    assign tc = on_board ? dx[TILE_ORDER +: COL_W] : '0;
    assign tr = on_board ? dy[TILE_ORDER +: ROW_W] : '0;

endmodule

// File: rtl/bomb_blast.sv
// -----------------------------------------------------------------------------
// bomb_blast
// Timed user-bomb controller. Accepts one arm request at a tile, burns a fuse
// of FUSE_FRAMES frame ticks, then flags a cross-shaped blast area through
// `explosion` for BLAST_FRAMES whole frames before returning to idle.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   frame_tick        : one-cycle pulse per frame, before the first visible pixel
//   detonate          : (only with BOMB_REMOTE_DETONATE_EN) cut the fuse short
//   pixel_x, pixel_y  : VGA pixel counters
//   explosion         : registered, 1 clk after the pixel position
//   bus (slave)       : arm request in; bomb status out
//
// Optional feature macro: BOMB_REMOTE_DETONATE_EN adds the `detonate` input.
// -----------------------------------------------------------------------------
module bomb_blast
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES  = 180,
    parameter int BLAST_FRAMES = 30,
    parameter int BLAST_RADIUS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
`ifdef BOMB_REMOTE_DETONATE_EN
    input  logic         detonate,
`endif
    input  logic [10:0]  pixel_x,
    input  logic [10:0]  pixel_y,
    output logic         explosion,
    bomb_blast_if.slave  bus
);

    localparam logic [7:0] FUSE_LOAD  = 8'(FUSE_FRAMES);
    localparam logic [7:0] BLAST_LOAD = 8'(BLAST_FRAMES);
    localparam logic [5:0] RADIUS     = 6'(BLAST_RADIUS);

    bomb_state_t      state_reg;
    logic [7:0]       fuse_reg;
    logic [7:0]       blast_cnt_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic             active_reg;
    logic             blasting_reg;
    logic             done_reg;
    logic             explosion_reg;

    logic             det;
    logic             arm_ok;
    logic             on_board;
    logic [COL_W-1:0] tc;
    logic [ROW_W-1:0] tr;
    logic [5:0]       dc;
    logic [5:0]       dr;
    logic             in_cross;

`ifdef BOMB_REMOTE_DETONATE_EN
    assign det = detonate;
`else
    assign det = 1'b0;
`endif

    assign arm_ok = bus.arm &&
                    (bus.arm_col < 5'(COLUMNS)) &&
                    (bus.arm_row < 4'(ROWS));

    pixel_to_tile u_tile (
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .on_board (on_board),
        .tc       (tc),
        .tr       (tr)
    );

    assign dc = abs_diff6({1'b0, tc}, {1'b0, col_reg});
    assign dr = abs_diff6({2'b00, tr}, {2'b00, row_reg});

    // Board edges clip the cross simply because off-board pixels never match.
    assign in_cross = on_board &&
                      (((tr == row_reg) && (dc <= RADIUS)) ||
                       ((tc == col_reg) && (dr <= RADIUS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fuse_reg      <= '0;
            blast_cnt_reg <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            active_reg    <= 1'b0;
            blasting_reg  <= 1'b0;
            done_reg      <= 1'b0;
            explosion_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            explosion_reg <= (state_reg == BLAST) && in_cross;

            case (state_reg)
                IDLE: begin
                    // A simultaneous frame_tick is irrelevant here: the fuse
                    // simply starts full.
                    if (arm_ok) begin
                        state_reg  <= FUSE;
                        col_reg    <= bus.arm_col;
                        row_reg    <= bus.arm_row;
                        fuse_reg   <= FUSE_LOAD;
                        active_reg <= 1'b1;
                    end
                end

                FUSE: begin
                    // The expiring tick takes precedence over detonate so the
                    // blast still starts on a frame boundary.
                    if (frame_tick && (fuse_reg == 8'd1)) begin
                        state_reg     <= BLAST;
                        fuse_reg      <= '0;
                        blast_cnt_reg <= BLAST_LOAD;
                        active_reg    <= 1'b0;
                        blasting_reg  <= 1'b1;
                    end else if (det) begin
                        fuse_reg <= 8'd1;
                    end else if (frame_tick) begin
                        fuse_reg <= fuse_reg - 8'd1;
                    end
                end

                BLAST: begin
                    if (frame_tick) begin
                        if (blast_cnt_reg == 8'd1) begin
                            state_reg     <= IDLE;
                            blast_cnt_reg <= '0;
                            blasting_reg  <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            blast_cnt_reg <= blast_cnt_reg - 8'd1;
                        end
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    active_reg   <= 1'b0;
                    blasting_reg <= 1'b0;
                end
            endcase
        end
    end

    assign explosion       = explosion_reg;
    assign bus.bomb_active = active_reg;
    assign bus.blasting    = blasting_reg;
    assign bus.bomb_col    = col_reg;
    assign bus.bomb_row    = row_reg;
    assign bus.fuse_left   = fuse_reg;
    assign bus.blast_done  = done_reg;

endmodule

// File: doc/bomb_blast.md
# bomb_blast

Timed user-bomb controller driving the `explosion` input of the board object matrix. It accepts one arm request at a tile and counts down a fuse in frame ticks. It then asserts `explosion` for every pixel of a cross-shaped blast area for a fixed number of whole frames, and returns to idle. The block sits between player/keyboard logic and the object matrix, beside the VGA pixel counters.

## Interface
- `X_MATRIX`, 11'h020, board left edge in pixels
- `Y_MATRIX`, 11'h060, board top edge in pixels
- `TILE_ORDER`, 5, tile size is 2**TILE_ORDER pixels
- `ROWS`, 11, board rows
- `COLUMNS`, 17, board columns
- `FUSE_FRAMES`, 180, frame ticks from arm to blast; legal range 1..255
- `BLAST_FRAMES`, 30, whole frames of blast; legal range 1..255
- `BLAST_RADIUS`, 2, cross arm length in tiles; legal range 0..15

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous reset, active-high
- `frame_tick` in 1: one-cycle pulse once per frame, before the first visible pixel
- `arm` in 1: one-cycle request to place a bomb
- `arm_col` in 5: tile column of the request
- `arm_row` in 4: tile row of the request
- `pixel_x` in 11: current pixel column
- `pixel_y` in 11: current pixel row
- `explosion` out 1: current pixel is in the blast area; registered
- `bomb_active` out 1: bomb placed, fuse burning
- `blasting` out 1: blast in progress
- `bomb_col` out 5: latched bomb column
- `bomb_row` out 4: latched bomb row
- `fuse_left` out 8: remaining fuse ticks
- `blast_done` out 1: one-cycle pulse at the end of the blast

## Operation
- FSM states are IDLE, FUSE and BLAST. `rst` forces IDLE from any state.
- IDLE to FUSE:
  - Condition: `arm`=1, `arm_col`<COLUMNS and `arm_row`<ROWS.
  - Action: latch the column and row, and load `fuse_left`=FUSE_FRAMES.
  - An out-of-range request is ignored.
- FUSE:
  - On `frame_tick`, if `fuse_left`>1, decrement it.
  - On `frame_tick`, if `fuse_left`==1, go to BLAST, set `fuse_left`=0 and load the blast counter with BLAST_FRAMES.
  - Because BLAST always starts on a tick, a blast covers whole frames only.
- BLAST:
  - On `frame_tick`, if the blast counter is >1, decrement it.
  - On `frame_tick`, if the blast counter is 1, go to IDLE and pulse `blast_done` on that same edge.
- `arm` outside IDLE is ignored; only one bomb is live at a time.
- `arm` and `frame_tick` in the same IDLE cycle: arm is taken and the tick does not decrement.
- Blast area: pixel is on the board and its tile (tc, tr) satisfies either:
  - tr==bomb_row and |tc−bomb_col|≤BLAST_RADIUS, or
  - tc==bomb_col and |tr−bomb_row|≤BLAST_RADIUS.
  - Tiles outside the board are never flagged; the board edges clip the cross.
- Tile index: tc=(pixel_x−X_MATRIX)>>TILE_ORDER and tr=(pixel_y−Y_MATRIX)>>TILE_ORDER, evaluated only when the pixel is on the board.
- Absolute differences use 6-bit unsigned arithmetic, so there is no wrap-around.
- `explosion` is 0 whenever the state is not BLAST.

## Timing
- Reset values: `explosion`=0, `bomb_active`=0, `blasting`=0, `bomb_col`=0, `bomb_row`=0, `fuse_left`=0, `blast_done`=0; blast counter 0.
- `explosion` latency is 1 clk from `pixel_x`/`pixel_y`. Consumers align the pixel counters accordingly.
- `bomb_active` and `blasting` are registered state decodes; they change on the edge after the causing event.
- Arm-to-first-blast-pixel: FUSE_FRAMES ticks, then the next visible pixel inside the area.
- Reset mid-FUSE or mid-BLAST clears the state and does not pulse `blast_done`.

## Configuration
- Macro `BOMB_REMOTE_DETONATE_EN` defined:
  - Adds input port `detonate` (1 bit).
  - `detonate`=1 in FUSE sets `fuse_left`=1, so the blast starts at the next `frame_tick`.
  - `detonate` in a cycle where FUSE also sees `frame_tick` with `fuse_left`==1 goes to BLAST normally.
  - `detonate` is ignored in IDLE and BLAST.
- Macro undefined: no `detonate` port; the fuse always runs its full length.

## Structure
- Package `bomb_pkg` holds:
  - the state enum `bomb_state_t` (IDLE, FUSE, BLAST);
  - the board geometry constants (ROWS, COLUMNS, X_MATRIX, Y_MATRIX, TILE_ORDER), shared with the object matrix;
  - the tile index widths (5 for column, 4 for row).
- Sub-module `pixel_to_tile` is combinational. It takes pixel_x/pixel_y and gives on_board, tc and tr, and is reusable by other board clients.
- The FSM, counters and blast-area compare live in `bomb_blast`.

## Test plan
- Arm at col 8, row 5 with FUSE_FRAMES=3 and BLAST_FRAMES=2:
  - `bomb_active`=1 for 3 ticks and `fuse_left` goes 3,2,1.
  - `blasting` lasts 2 frames, then a single `blast_done` pulse.
- During a blast at (8,5) with radius 2:
  - pixel (X_MATRIX+10·32, Y_MATRIX+5·32) → `explosion`=1;
  - tile (11,5) → 0;
  - tile (8,3) → 1;
  - tile (9,6) → 0.
- Arm at (0,0) with radius 2: only tiles (0..2,0) and (0,0..2) are flagged, and pixels left of/above the board give 0.
- Arm at col 17 → ignored. A second `arm` during FUSE → latched column/row and `fuse_left` unchanged.
- `rst`=1 for one cycle mid-BLAST → all outputs at reset values next cycle and no `blast_done`.
- With `BOMB_REMOTE_DETONATE_EN`: arm with FUSE_FRAMES=180, pulse `detonate` at `fuse_left`=100 → `blasting`=1 after the next `frame_tick`.
